// File: rtl/rotary_event_encoder.sv
// Rotary encoder conditioning: sync, quadrature decode, push-switch debounce, event queue. ROTARY_POSITION_EN adds a signed position counter.
// Latency: a step is queued 3 clk after both raw pins read high; a press is queued 1 clk after its debounce completes.
// Backpressure: event_valid/event_ready pop the head entry; a write into a full queue with no pop is dropped and sets the sticky overflow flag.

module fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_acc,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign rd_vld = (count != '0);
    assign pop    = rd_vld && rd_rdy;
    // A pop in the same cycle frees the slot, so a full queue still takes the write.
    assign wr_acc = wr_vld && ((count != FULL) || pop);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module rotary_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_AW         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rotary_a,
    input  logic               rotary_b,
    input  logic               rotary_center,
    output logic               event_valid,
    output logic [1:0]         event_code,
    input  logic               event_ready,
    output logic [FIFO_AW:0]   event_count,
    output logic               overflow
`ifdef ROTARY_POSITION_EN
    ,
    output logic signed [7:0]  position
`endif
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       a_sync, b_sync, c_sync;
    logic             a_s, b_s, c_s;
    logic             q1, q1_d, q2;
    logic             step;
    logic [1:0]       step_code;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_level;
    logic [1:0]       primed;
    logic             armed;
    logic             press;
    logic             pending_press;
    logic             wr_vld;
    logic [1:0]       wr_code;
    logic             wr_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
            c_sync <= '0;
        end else begin
            a_sync <= {a_sync[0], rotary_a};
            b_sync <= {b_sync[0], rotary_b};
            c_sync <= {c_sync[0], rotary_center};
        end
    end

    assign a_s = a_sync[1];
    assign b_s = b_sync[1];
    assign c_s = c_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1   <= 1'b0;
            q2   <= 1'b0;
            q1_d <= 1'b0;
        end else begin
            if (a_s && b_s)        q1 <= 1'b1;
            else if (!a_s && !b_s) q1 <= 1'b0;
            if (!a_s && b_s)       q2 <= 1'b1;
            else if (a_s && !b_s)  q2 <= 1'b0;
            q1_d <= q1;
        end
    end

    // q2 remembers which pin led into the detent, so it fixes direction at the q1 rise.
    assign step      = q1 && !q1_d;
    assign step_code = q2 ? 2'b10 : 2'b01;

    // armed waits for a genuine released sample, so a button held through reset never fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            primed    <= '0;
            armed     <= 1'b0;
        end else begin
            primed <= {primed[0], 1'b1};
            if (primed[1] && !c_s) armed <= 1'b1;
            if (c_s == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_MAX) begin
                deb_level <= c_s;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press   = (c_s != deb_level) && (deb_cnt == CNT_MAX) && c_s && armed;
    assign wr_vld  = step || press || pending_press;
    assign wr_code = step ? step_code : 2'b11;

    // A press colliding with a step waits one cycle; it is retired whether written or dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_press <= 1'b0;
        else       pending_press <= step && (press || pending_press);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 overflow <= 1'b0;
        else if (wr_vld && !wr_acc) overflow <= 1'b1;
    end

    fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (wr_vld),
        .wr_dat (wr_code),
        .wr_acc (wr_acc),
        .rd_vld (event_valid),
        .rd_rdy (event_ready),
        .rd_dat (event_code),
        .count  (event_count)
    );

`ifdef ROTARY_POSITION_EN
    // Press clears the position even when a step lands in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     position <= '0;
        else if (press) position <= '0;
        else if (step)  position <= q2 ? position - 8'sd1 : position + 8'sd1;
    end
`endif
endmodule
